// File: rtl/contador_bcd_param_pkg.sv
// contador_bcd_param_pkg: shared width, parameter legality check and max-count helper.
package contador_bcd_param_pkg;
  localparam int BCD_W = 4;
  function automatic bit params_ok(int div, int digits, int top_mod);
    return div >= 1 && digits >= 1 && digits <= 8 && top_mod >= 2 && top_mod <= 10;
  endfunction
  function automatic logic [31:0] max_value(int digits, int top_mod);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < digits; i++)
      v[BCD_W*i +: BCD_W] = (i == digits - 1) ? BCD_W'(top_mod - 1) : BCD_W'(9);
    return v;
  endfunction
endpackage

// File: rtl/contador_bcd_param_digito_bcd.sv
// digito_bcd: one modulus-MOD BCD digit with load, up/down step and wrap-out for cascading.
module digito_bcd
  import contador_bcd_param_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_in,
  input  logic             up_down,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] digit,
  output logic             step_out
);
  localparam logic [BCD_W-1:0] TOP = BCD_W'(MOD - 1);
  assign step_out = step_in && (up_down ? digit == TOP : digit == '0);
  // out-of-range digits fall to 0 on the next step in either direction
  always_ff @(posedge clk or posedge reset)
    if (reset) digit <= '0;
    else if (load) digit <= load_digit;
    else if (step_in)
      digit <= up_down ? (digit >= TOP ? '0 : digit + 1'b1)
                       : (digit == '0 ? TOP : digit > TOP ? '0 : digit - 1'b1);
endmodule

// File: rtl/contador_bcd_param.sv
// contador_bcd_param: multi-digit BCD up/down counter with prescaler, load and tick/carry pulses.
module contador_bcd_param
  import contador_bcd_param_pkg::*;
#(
  parameter int DIV     = 50_000_000,
  parameter int DIGITS  = 2,
  parameter int TOP_MOD = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  output logic [BCD_W*DIGITS-1:0] outcome,
  output logic                    tick,
  output logic                    carry
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  if (!params_ok(DIV, DIGITS, TOP_MOD)) begin : g_bad_params
    $error("contador_bcd_param: illegal DIV/DIGITS/TOP_MOD");
  end
  logic [PW-1:0] r_presc;
  logic          w_step;
  logic [DIGITS:0] w_chain;
  // load wins over a coincident step, so the step is masked here
  assign w_step = enable && !load && r_presc == P_LAST;
  assign w_chain[0] = w_step;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_presc <= '0;
      tick    <= 1'b0;
      carry   <= 1'b0;
    end else begin
      tick  <= w_step;
      carry <= w_chain[DIGITS];
      if (load) r_presc <= '0;
      else if (enable) r_presc <= w_step ? '0 : r_presc + 1'b1;
    end
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    localparam int M = (g == DIGITS - 1) ? TOP_MOD : 10;
    logic [BCD_W-1:0] w_ld;
    assign w_ld = load_value[BCD_W*g +: BCD_W] >= BCD_W'(M) ? '0 : load_value[BCD_W*g +: BCD_W];
    digito_bcd #(.MOD(M)) u_dig (
      .clk       (clk),
      .reset     (reset),
      .step_in   (w_chain[g]),
      .up_down   (up_down),
      .load      (load),
      .load_digit(w_ld),
      .digit     (outcome[BCD_W*g +: BCD_W]),
      .step_out  (w_chain[g+1])
    );
  end
endmodule

// File: tb/tb_contador_bcd_param.sv
// tb_contador_bcd_param: integer-count reference model with step scoreboard, directed plus random stimulus.
module tb_contador_bcd_param;
  import contador_bcd_param_pkg::*;
  localparam int DIV = 4, DIGITS = 2, TOP_MOD = 6, W = BCD_W * DIGITS;
  localparam int N = TOP_MOD * 10 ** (DIGITS - 1);
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, up_down = 1'b1, load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] outcome;
  logic tick, carry;
  int tests = 0, fails = 0;
  int m_val = 0, m_presc = 0;
  bit m_tick = 0, m_carry = 0, m_last_up = 1;
  logic [W:0] sb_q[$];
  always #5 clk = ~clk;
  contador_bcd_param #(.DIV(DIV), .DIGITS(DIGITS), .TOP_MOD(TOP_MOD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .outcome(outcome), .tick(tick), .carry(carry)
  );
  function automatic int sanitize(logic [W-1:0] lv);
    int v = 0, p = 1, d, m;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((lv >> (BCD_W * i)) & W'(15));
      m = (i == DIGITS - 1) ? TOP_MOD : 10;
      if (d >= m) d = 0;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction
  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[BCD_W*i +: BCD_W] = BCD_W'(v % 10);
      v /= 10;
    end
    return r;
  endfunction
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  // reference model: count kept as a plain integer modulo N
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_val = 0; m_presc = 0; m_tick = 0; m_carry = 0;
      sb_q.delete();
    end else begin
      m_tick = 0; m_carry = 0;
      if (load) begin
        m_val = sanitize(load_value);
        m_presc = 0;
      end else if (enable) begin
        if (m_presc == DIV - 1) begin
          m_presc = 0;
          m_last_up = up_down;
          m_carry = up_down ? (m_val == N - 1) : (m_val == 0);
          m_val = up_down ? (m_val + 1) % N : (m_val + N - 1) % N;
          m_tick = 1;
          sb_q.push_back({to_bcd(m_val), m_carry});
        end else m_presc++;
      end
    end
  always @(negedge clk) begin
    logic [W:0] e;
    check("outcome", 32'(outcome), 32'(to_bcd(m_val)));
    check("tick", 32'(tick), 32'(m_tick));
    check("carry", 32'(carry), 32'(m_carry));
    if (tick) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_step", 32'({outcome, carry}), 32'(e));
      end
      if (carry) check("wrap_value", 32'(outcome), m_last_up ? 32'd0 : max_value(DIGITS, TOP_MOD));
    end
  end
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic do_load(logic [W-1:0] v);
    load = 1'b1; load_value = v;
    cyc(1);
    load = 1'b0;
  endtask
  initial begin
    bit rst_pending = 0;
    cyc(2);
    reset = 1'b0;
    check("reset_outcome", 32'(outcome), 32'd0);
    check("reset_tick", 32'({tick, carry}), 32'd0);
    enable = 1'b1; up_down = 1'b1;
    cyc(12);
    do_load(8'h58);
    check("load_58", 32'(outcome), 32'h58);
    cyc(10);
    do_load(8'h00);
    up_down = 1'b0;
    cyc(10);
    cyc(2);
    enable = 1'b0;
    cyc(10);
    enable = 1'b1;
    cyc(6);
    for (int k = 0; k < DIV && m_presc != DIV - 1; k++) cyc(1);
    do_load(8'h7A);
    check("load_7A", 32'(outcome), 32'h00);
    check("load_7A_tick", 32'(tick), 32'd0);
    cyc(6);
    do_load(8'h37);
    check("load_37", 32'(outcome), 32'h37);
    up_down = 1'b1;
    do_load(8'h42);
    cyc(2);
    #1 reset = 1'b1;
    #1 check("async_reset", 32'({outcome, tick, carry}), 32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(8);
    for (int c = 0; c < 3000; c++) begin
      if (rst_pending) begin
        reset = 1'b0;
        rst_pending = 0;
      end
      enable = ($urandom % 10) != 0;
      if ($urandom % 16 == 0) up_down = ~up_down;
      load = ($urandom % 25) == 0;
      load_value = W'($urandom);
      if ($urandom % 300 == 0) begin
        #1 reset = 1'b1;
        rst_pending = 1;
      end
      cyc(1);
    end
    reset = 1'b0; load = 1'b0;
    cyc(4);
    @(negedge clk);
    #1 check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
